// File: rtl/mac_accumulator.sv
// mac_accumulator
// Sequential dot-product stage wrapped around an external combinational
// signed multiplier. Operand pairs are accepted over a valid/ready handshake
// and registered onto the multiplier inputs; one cycle later the product is
// sign-extended and added into a saturating accumulator. After LEN products
// the sum is presented downstream over a valid/ready handshake.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept a pair
//   in_a/in_b  signed N-bit operands
//   clr        synchronous frame abort (same effect as reset, wins over handshakes)
//   mul_d/c    registered operands driving the multiplier d/c inputs
//   mul_y      signed 2N-bit product returned by the multiplier
//   out_valid  frame result valid
//   out_ready  downstream accepts result
//   out_sum    signed ACC_W-bit saturated sum
//   out_sat    a clamp occurred somewhere in this frame (sticky)
//
// state   | meaning
// --------+-----------------------------------------
// ST_ACC  | accepting pairs and accumulating products
// ST_DONE | frame result held for downstream
module mac_accumulator #(
  parameter int N     = 4,
  parameter int LEN   = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     in_a,
  input  logic signed [N-1:0]     in_b,
  input  logic                    clr,
  output logic signed [N-1:0]     mul_d,
  output logic signed [N-1:0]     mul_c,
  input  logic signed [2*N-1:0]   mul_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_sat
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);
  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        acc_cnt;
  logic [CNT_W-1:0]        add_cnt;
  logic                    p_vld;
  logic                    accept;
  logic                    last_add;
  logic signed [ACC_W:0]   prod_ext;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W:0]   sum_wide;
  logic                    ovf;
  logic signed [ACC_W-1:0] sum_sat;

  assign in_ready  = (state == ST_ACC) && (acc_cnt < LEN_C);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready && !clr;
  assign last_add  = p_vld && (add_cnt == LAST_C);

  // One guard bit above ACC_W: overflow shows up as disagreement between the
  // top two bits, and the guard bit alone tells the direction.
  always_comb begin
    prod_ext = {{(ACC_W+1-2*N){mul_y[2*N-1]}}, mul_y};
    sum_ext  = {out_sum[ACC_W-1], out_sum};
    sum_wide = sum_ext + prod_ext;
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (ovf) begin
      sum_sat = sum_wide[ACC_W] ? SUM_MIN : SUM_MAX;
    end else begin
      sum_sat = sum_wide[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_ACC;
    end else begin
      case (state)
        ST_ACC:  if (last_add)  state_nxt = ST_DONE;
        ST_DONE: if (out_ready) state_nxt = ST_ACC;
        default: state_nxt = ST_ACC;
      endcase
    end
  end

  // No pair is accepted and no product is pending while in ST_DONE, so the
  // handshake clear below never collides with the accept/add updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_d   <= '0;
      mul_c   <= '0;
      p_vld   <= 1'b0;
      acc_cnt <= '0;
      add_cnt <= '0;
      out_sum <= '0;
      out_sat <= 1'b0;
    end else if (clr) begin
      mul_d   <= '0;
      mul_c   <= '0;
      p_vld   <= 1'b0;
      acc_cnt <= '0;
      add_cnt <= '0;
      out_sum <= '0;
      out_sat <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        mul_d   <= in_a;
        mul_c   <= in_b;
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (p_vld) begin
        out_sum <= sum_sat;
        out_sat <= out_sat | ovf;
        add_cnt <= add_cnt + CNT_W'(1);
      end
      if (out_valid && out_ready) begin
        out_sum <= '0;
        out_sat <= 1'b0;
        acc_cnt <= '0;
        add_cnt <= '0;
      end
    end
  end

endmodule
